aes128_hardened_decrypt: RTL

AES128_HARDENED_DECRYPT -- requirements
Module: aes128_hardened_decrypt

---
 rtl/aes_pkg.sv | 128 ++++++++++++
 rtl/aes_inv_round.sv | 47 ++++
 rtl/aes128_hardened_decrypt.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the hardened decrypt block:
//   - forward S-box (key expansion) and inverse S-box (InvSubBytes)
//   - rcon table for the key schedule
//   - GF(2^8) helpers for InvMixColumns
//   - decrypt FSM state enum and round-count constant
// Byte order everywhere: byte 0 is bits [127:120]; byte i sits at row i%4,
// column i/4 of the AES state matrix.
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEYEXP = 3'd1,
        PASS1  = 3'd2,
        PASS2  = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5
    } aes_state_e;

    // Tables stored as one flat vector, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (only 09/0b/0d/0e are needed).
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (m[0] ? b : 8'h00) ^ (m[1] ? x2 : 8'h00) ^
               (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // One forward key-schedule step: rk(i) -> rk(i+1).
    function automatic logic [127:0] key_next(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        {w0, w1, w2, w3} = rk;
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// -----------------------------------------------------------------------------
// aes_inv_round
// One combinational AES inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
// InvMixColumns is skipped when final_round is set.
// Ports:
//   state       in  [127:0]  current state
//   round_key   in  [127:0]  round key for this round
//   final_round in           1 = last round (no InvMixColumns)
//   state_next  out [127:0]  resulting state
// -----------------------------------------------------------------------------
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         final_round,
    output logic [127:0] state_next
);

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;
    logic [127:0] mixed;

    always_comb begin
        shifted = '0;
        subbed  = '0;
        mixed   = '0;
        // Row r rotates right by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127 - 8 * (4 * c + r) -: 8] =
                    state[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        for (int i = 0; i < 16; i++) begin
            subbed[127 - 8 * i -: 8] = inv_sbox(shifted[127 - 8 * i -: 8]);
        end
        keyed = subbed ^ round_key;
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32 * c -: 32] = inv_mix_col(keyed[127 - 32 * c -: 32]);
        end
        state_next = final_round ? keyed : mixed;
    end

endmodule

// File: rtl/aes128_hardened_decrypt.sv
// -----------------------------------------------------------------------------
// aes128_hardened_decrypt
// Iterative AES-128 decryption, one round per clock, with an optional
// redundant second pass compared against the first to detect faults.
//
// Build option: AES_DEC_REDUNDANT_CHECK_EN
//   defined   : PASS2 + CHECK present, fault_alert live, inject_fault honoured.
//               Accept -> valid latency 31 cycles, back-to-back period 33.
//   undefined : PASS1 goes straight to DONE, fault_alert tied 0,
//               inject_fault ignored. Latency 21 cycles, period 23.
//
// Ports:
//   clk          in         clock, rising edge
//   rst_n        in         asynchronous active-low reset
//   start        in         request pulse, sampled only in IDLE
//   ciphertext   in  [127:0] block to decrypt (captured on accepted start)
//   key          in  [127:0] cipher key (captured on accepted start)
//   inject_fault in         flip state bit 0 after round 5 of PASS1
//   plaintext    out [127:0] result, held between completions
//   valid        out        one-cycle pulse in DONE
//   busy         out        high whenever the FSM is not IDLE
//   fault_alert  out        sticky redundancy-mismatch flag
//
// state  | meaning
// IDLE   | waiting for start
// KEYEXP | rk1..rk10 computed, one per cycle
// PASS1  | primary decryption, one inverse round per cycle
// PASS2  | redundant decryption on a separate state register
// CHECK  | compare PASS1 and PASS2 results
// DONE   | plaintext loaded and valid pulsed
// -----------------------------------------------------------------------------
module aes128_hardened_decrypt
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    input  logic         inject_fault,
    output logic [127:0] plaintext,
    output logic         valid,
    output logic         busy,
    output logic         fault_alert
);

    localparam logic [3:0] LAST_RND  = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0] FAULT_RND = 4'd4;   // after round 5 (index 4)

    aes_state_e   fsm;
    logic [3:0]   rnd_cnt;
    logic [127:0] rk_bank [0:NUM_ROUNDS];
    logic [127:0] ct_q;
    logic [127:0] state1;
    logic [127:0] rk_new;
    logic [127:0] rk_cur;
    logic [127:0] inv1_out;
    logic         last_rnd;

    assign rk_new   = key_next(rk_bank[rnd_cnt], rcon(rnd_cnt));
    assign rk_cur   = rk_bank[LAST_RND - rnd_cnt];
    assign last_rnd = (rnd_cnt == LAST_RND);
    assign busy     = (fsm != IDLE);

    aes_inv_round u_inv_round_p1 (
        .state       (state1),
        .round_key   (rk_cur),
        .final_round (last_rnd),
        .state_next  (inv1_out)
    );

`ifdef AES_DEC_REDUNDANT_CHECK_EN
    logic         fault_q;
    logic         alert_q;
    logic [127:0] state2;
    logic [127:0] inv2_out;
    logic         fault_hit;

    assign fault_hit   = fault_q && (rnd_cnt == FAULT_RND);
    assign fault_alert = alert_q;

    aes_inv_round u_inv_round_p2 (
        .state       (state2),
        .round_key   (rk_cur),
        .final_round (last_rnd),
        .state_next  (inv2_out)
    );
`else
    logic unused_inject;
    logic [3:0] unused_fault_rnd;

    assign unused_inject    = inject_fault;
    assign unused_fault_rnd = FAULT_RND;
    assign fault_alert      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            rnd_cnt   <= '0;
            plaintext <= '0;
            valid     <= 1'b0;
            ct_q      <= '0;
            state1    <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                rk_bank[i] <= '0;
            end
`ifdef AES_DEC_REDUNDANT_CHECK_EN
            fault_q   <= 1'b0;
            alert_q   <= 1'b0;
            state2    <= '0;
`endif
        end else begin
            case (fsm)
                IDLE: begin
                    if (start) begin
                        ct_q       <= ciphertext;
                        rk_bank[0] <= key;
                        rnd_cnt    <= '0;
                        fsm        <= KEYEXP;
`ifdef AES_DEC_REDUNDANT_CHECK_EN
                        fault_q    <= inject_fault;
                        alert_q    <= 1'b0;
`endif
                    end
                end

                KEYEXP: begin
                    rk_bank[rnd_cnt + 4'd1] <= rk_new;
                    if (last_rnd) begin
                        // rk10 is only now being written, so take it from the
                        // expansion output for the initial AddRoundKey.
                        state1  <= ct_q ^ rk_new;
                        rnd_cnt <= '0;
                        fsm     <= PASS1;
                    end else begin
                        rnd_cnt <= rnd_cnt + 4'd1;
                    end
                end

                PASS1: begin
`ifdef AES_DEC_REDUNDANT_CHECK_EN
                    state1 <= inv1_out ^ {127'd0, fault_hit};
`else
                    state1 <= inv1_out;
`endif
                    if (last_rnd) begin
                        rnd_cnt <= '0;
`ifdef AES_DEC_REDUNDANT_CHECK_EN
                        state2  <= ct_q ^ rk_bank[NUM_ROUNDS];
                        fsm     <= PASS2;
`else
                        fsm     <= DONE;
`endif
                    end else begin
                        rnd_cnt <= rnd_cnt + 4'd1;
                    end
                end

`ifdef AES_DEC_REDUNDANT_CHECK_EN
                PASS2: begin
                    state2 <= inv2_out;
                    if (last_rnd) begin
                        rnd_cnt <= '0;
                        fsm     <= CHECK;
                    end else begin
                        rnd_cnt <= rnd_cnt + 4'd1;
                    end
                end

                CHECK: begin
                    if (state1 == state2) begin
                        plaintext <= state1;
                        valid     <= 1'b1;
                        fsm       <= DONE;
                    end else begin
                        alert_q   <= 1'b1;
                        plaintext <= '0;
                        fsm       <= IDLE;
                    end
                end
`endif

                DONE: begin
                    // Entered with valid already set after CHECK; without the
                    // check stage the first DONE cycle loads the result.
                    if (valid) begin
                        valid <= 1'b0;
                        fsm   <= IDLE;
                    end else begin
                        plaintext <= state1;
                        valid     <= 1'b1;
                    end
                end

                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule
